// File: rtl/pacman_pio_pkg.sv
// Shared definitions for the pacman PIO bank: register offsets, edge modes and byte-lane merge.
package pacman_pio_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  function automatic int off_in_data(input int num_out);
    return num_out;
  endfunction

  function automatic int off_irq_mask(input int num_out);
    return num_out + 1;
  endfunction

  function automatic int off_edge_cap(input int num_out);
    return num_out + 2;
  endfunction

  function automatic int off_toggle(input int num_out);
    return num_out + 3;
  endfunction

  // Lanes with be=1 take new_val, the rest keep old_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/pio_edge_sync.sv
// Two-flop synchroniser for the input pins plus a history register for edge detection.
module pio_edge_sync
  import pacman_pio_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int EDGE_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] pin,
  output logic [IN_W-1:0] sync_data,
  output logic [IN_W-1:0] edge_pulse
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  logic [IN_W-1:0] sync1_r;
  logic [IN_W-1:0] sync2_r;
  logic [IN_W-1:0] prev_r;

  // Synchroniser chain and previous-value history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {IN_W{1'b0}};
      sync2_r <= {IN_W{1'b0}};
      prev_r  <= {IN_W{1'b0}};
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Edge pulses from the synchronised value against its history.
  always_comb begin
    case (MODE)
      EDGE_RISE: edge_pulse = sync2_r & ~prev_r;
      EDGE_FALL: edge_pulse = ~sync2_r & prev_r;
      EDGE_ANY:  edge_pulse = sync2_r ^ prev_r;
      default:   edge_pulse = sync2_r & ~prev_r;
    endcase
  end

  assign sync_data = sync2_r;

endmodule

// File: rtl/pacman_pio_bank.sv
// Avalon-MM PIO bank: NUM_OUT output channels, one synchronised input channel with
// edge capture and a maskable level interrupt.
module pacman_pio_bank
  import pacman_pio_pkg::*;
#(
  parameter int                NUM_OUT   = 4,
  parameter int                DATA_W    = 32,
  parameter int                IN_W      = 2,
  parameter int                EDGE_MODE = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  localparam int               ADDR_W    = $clog2(NUM_OUT + 4)
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W/8-1:0]       avs_byteenable,
  input  logic [DATA_W-1:0]         avs_writedata,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      irq,
  input  logic [IN_W-1:0]           in_export,
  output logic [NUM_OUT*DATA_W-1:0] out_export
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(off_in_data(NUM_OUT));
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(off_irq_mask(NUM_OUT));
  localparam logic [ADDR_W-1:0] A_CAP  = ADDR_W'(off_edge_cap(NUM_OUT));
  localparam logic [ADDR_W-1:0] A_TOG  = ADDR_W'(off_toggle(NUM_OUT));

  logic [DATA_W-1:0] out_r     [NUM_OUT];
  logic [DATA_W-1:0] out_nxt_s [NUM_OUT];
  logic [IN_W-1:0]   mask_r;
  logic [IN_W-1:0]   cap_r;
  logic [IN_W-1:0]   sync_s;
  logic [IN_W-1:0]   edge_s;
  logic [IN_W-1:0]   mask_nxt_s;
  logic [IN_W-1:0]   clr_s;
  logic [DATA_W-1:0] tog_s;
  logic [DATA_W-1:0] rdata_s;
  logic [DATA_W-1:0] readdata_r;
  logic              rdv_r;
  logic [31:0]       wdata_pad_s;
  logic [3:0]        be_pad_s;
  logic              wr_mask_s;
  logic              wr_cap_s;
  logic              wr_tog_s;

  pio_edge_sync #(
    .IN_W      (IN_W),
    .EDGE_MODE (EDGE_MODE)
  ) u_sync (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .pin        (in_export),
    .sync_data  (sync_s),
    .edge_pulse (edge_s)
  );

  // Widen bus data and byte enables to the 32-bit merge helper.
  always_comb begin
    wdata_pad_s = 32'h0;
    wdata_pad_s[DATA_W-1:0] = avs_writedata;
    be_pad_s = 4'h0;
    be_pad_s[BE_W-1:0] = avs_byteenable;
  end

  // Write decode and next values for every writable register.
  always_comb begin
    wr_mask_s  = avs_write && (avs_address == A_MASK);
    wr_cap_s   = avs_write && (avs_address == A_CAP);
    wr_tog_s   = avs_write && (avs_address == A_TOG);
    mask_nxt_s = IN_W'(byte_merge(32'(mask_r), wdata_pad_s, be_pad_s));
    clr_s      = wr_cap_s ? IN_W'(byte_merge(32'h0, wdata_pad_s, be_pad_s)) : {IN_W{1'b0}};
    tog_s      = DATA_W'(byte_merge(32'(out_r[0]), 32'(out_r[0]) ^ wdata_pad_s, be_pad_s));
    for (int k = 0; k < NUM_OUT; k++) begin
      if (avs_write && (avs_address == ADDR_W'(k))) begin
        out_nxt_s[k] = DATA_W'(byte_merge(32'(out_r[k]), wdata_pad_s, be_pad_s));
      end else if ((k == 0) && wr_tog_s) begin
        out_nxt_s[k] = tog_s;
      end else begin
        out_nxt_s[k] = out_r[k];
      end
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    case (avs_address)
      A_IN:    rdata_s[IN_W-1:0] = sync_s;
      A_MASK:  rdata_s[IN_W-1:0] = mask_r;
      A_CAP:   rdata_s[IN_W-1:0] = cap_r;
      default: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          rdata_s = rdata_s | (out_r[k] & {DATA_W{avs_address == ADDR_W'(k)}});
        end
      end
    endcase
  end

  // Register file, edge capture (new edges win over W1C) and read response.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_OUT; k++) out_r[k] <= RESET_VAL;
      mask_r     <= {IN_W{1'b0}};
      cap_r      <= {IN_W{1'b0}};
      readdata_r <= {DATA_W{1'b0}};
      rdv_r      <= 1'b0;
    end else begin
      out_r      <= out_nxt_s;
      mask_r     <= wr_mask_s ? mask_nxt_s : mask_r;
      cap_r      <= (cap_r & ~clr_s) | edge_s;
      readdata_r <= avs_read ? rdata_s : readdata_r;
      rdv_r      <= avs_read;
    end
  end

  // Flatten the channel array onto the export bus.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) out_export[k*DATA_W +: DATA_W] = out_r[k];
  end

  assign avs_readdata      = readdata_r;
  assign avs_readdatavalid = rdv_r;
  assign irq               = |(cap_r & mask_r);

endmodule

// File: tb/tb_pacman_pio_bank.sv
// Bench for pacman_pio_bank: table of write/readback vectors plus hand-written
// sequences for edge timing, W1C collision, toggle and reset during a read.
module tb_pacman_pio_bank;

  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 32;
  localparam int IN_W    = 2;
  localparam int ADDR_W  = 3;
  localparam logic [31:0] RV = 32'h0000_00A5;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [ADDR_W-1:0]         avs_address;
  logic                      avs_read;
  logic                      avs_write;
  logic [3:0]                avs_byteenable;
  logic [DATA_W-1:0]         avs_writedata;
  logic [DATA_W-1:0]         avs_readdata;
  logic                      avs_readdatavalid;
  logic                      irq;
  logic [IN_W-1:0]           in_export;
  logic [NUM_OUT*DATA_W-1:0] out_export;

  pacman_pio_bank #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .IN_W(IN_W), .EDGE_MODE(0), .RESET_VAL(RV)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid), .irq(irq),
    .in_export(in_export), .out_export(out_export)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] exp; string name; } exp_t;
  typedef struct { logic [2:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_byteenable = be; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    push_exp(exp, name);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  // Scoreboard: every readdatavalid pops one expected value.
  always @(negedge clk) begin
    exp_t e;
    if (avs_readdatavalid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rdv", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk(e.name, avs_readdata, e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    vecs[0] = '{3'd2, 4'b0101, 32'hDEAD_BEEF, 32'h00AD_00EF};
    vecs[1] = '{3'd1, 4'b1111, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{3'd3, 4'b1000, 32'hFFFF_FFFF, 32'hFF00_00A5};
    vecs[3] = '{3'd0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_00A5};
    vecs[4] = '{3'd5, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[5] = '{3'd5, 4'b0010, 32'h0000_0000, 32'h0000_0003};
    vecs[6] = '{3'd4, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{3'd7, 4'b1111, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{3'd5, 4'b1111, 32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b0; avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = 4'h0; avs_writedata = 32'h0; in_export = 2'b00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NUM_OUT; k++) chk("reset_out", out_export[k*32 +: 32], RV);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_rdv", {31'd0, avs_readdatavalid}, 32'd0);
    rst_n = 1'b1;
    rd(3'd4, 32'h0, "reset_in_data");

    // Table: write, check the export on the next cycle, then read back.
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      if (vecs[i].addr < 3'd4) chk("vec_out_export", out_export[vecs[i].addr*32 +: 32], vecs[i].exp);
      rd(vecs[i].addr, vecs[i].exp, "vec_readback");
    end

    // Captured edge with mask clear, then mask set raises irq the next cycle.
    @(negedge clk); in_export = 2'b01;
    repeat (4) @(negedge clk);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    rd(3'd6, 32'h1, "cap_bit0");
    wr(3'd5, 4'hF, 32'h1);
    chk("mask_irq_next", {31'd0, irq}, 32'd1);
    rd(3'd4, 32'h1, "in_data_synced");
    wr(3'd6, 4'hF, 32'h1);
    chk("w1c_irq_clear", {31'd0, irq}, 32'd0);

    // Pin-to-irq latency.
    wr(3'd5, 4'hF, 32'h3);
    @(negedge clk); in_export = 2'b11;
    cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (irq && cnt == 0) cnt = c;
    end
    chk("edge_latency", cnt, 32'd3);
    rd(3'd6, 32'h2, "cap_bit1");

    // Falling edge ignored in rising mode; then W1C colliding with a new edge.
    @(negedge clk); in_export = 2'b10;
    repeat (4) @(negedge clk);
    wr(3'd6, 4'hF, 32'h2);
    chk("fall_ignored_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); in_export = 2'b11;
    @(negedge clk);
    @(negedge clk);
    avs_address = 3'd6; avs_byteenable = 4'hF; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
    chk("collision_irq", {31'd0, irq}, 32'd1);
    rd(3'd6, 32'h1, "collision_cap");

    // OUT_TOGGLE.
    wr(3'd7, 4'hF, 32'h0000_000F);
    chk("toggle_out0", out_export[31:0], 32'h0000_00AA);
    rd(3'd0, 32'h0000_00AA, "toggle_read_out0");
    rd(3'd7, 32'h0, "toggle_reads_zero");
    wr(3'd7, 4'b0010, 32'hFFFF_FFFF);
    chk("toggle_be", out_export[31:0], 32'h0000_FFAA);

    // Read and write of the same register in one cycle returns the old value.
    @(negedge clk);
    avs_address = 3'd1; avs_byteenable = 4'hF; avs_writedata = 32'h1111_1111;
    avs_write = 1'b1; avs_read = 1'b1;
    push_exp(32'h1234_5678, "rw_same_cycle");
    @(negedge clk); avs_write = 1'b0; avs_read = 1'b0;
    rd(3'd1, 32'h1111_1111, "rw_after");

    // Reset asserted while a read response is pending.
    @(negedge clk); in_export = 2'b00;
    repeat (4) @(negedge clk);
    @(negedge clk); avs_address = 3'd1; avs_read = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk); avs_read = 1'b0;
    chk("rst_rdv_dropped", {31'd0, avs_readdatavalid}, 32'd0);
    for (int k = 0; k < NUM_OUT; k++) chk("rst_out", out_export[k*32 +: 32], RV);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rd(3'd1, RV, "rst_out1_read");
    rd(3'd5, 32'h0, "rst_mask");
    rd(3'd6, 32'h0, "rst_cap");
    rd(3'd4, 32'h0, "rst_in_data");

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) chk("drain_pending_reads", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
